router_pkt_tx: RTL and testbench
================================

// Module: router_pkt_tx
// PURPOSE
//  Source-side packet transmitter for the 1x3 router input port; the sending end of the
//  header/payload/parity byte protocol that the router FIFOs store and drain.
//  Takes a descriptor (dest address, payload length), buffers the whole payload, then sends
//  header, payload and parity bytes while honouring router busy. Used as on-chip traffic
//  source and as the stimulus engine for router system tests.
// PARAMETERS
//  WIDTH      8  data byte width; header = {len[WIDTH-3:0], addr[1:0]}
//  LEN_W      6  payload length field width; buffer depth = 2**LEN_W (64)
//  MAX_RETRY  2  resend limit per packet; used only with ROUTER_TX_RETRY_EN
// PORTS
//  clock       in   1      single clock, all logic on rising edge
//  reset       in   1      synchronous, active-high reset
//  start       in   1      descriptor strobe, sampled in IDLE only
//  dest_addr   in   2      destination port 0..2; 3 is illegal
//  pay_len     in   LEN_W  payload bytes 1..63; 0 is illegal
//  wr_en       in   1      payload byte strobe, sampled in LOAD only
//  wr_data     in   WIDTH  payload byte
//  busy        in   1      router stall: presented byte is held while high
//  err         in   1      router parity-error flag (retry feature only; ignored otherwise)
//  pkt_valid   out  1      high while header/payload is presented, low on parity byte
//  data_out    out  WIDTH  presented byte
//  tx_idle     out  1      state==IDLE (combinational decode)
//  reject      out  1      1-cycle pulse: illegal descriptor dropped
//  done        out  1      1-cycle pulse: packet complete
//  fail        out  1      1-cycle pulse with done: retries exhausted (0 without macro)
// BEHAVIOUR
//  - Reset: state IDLE; pkt_valid=0, data_out=0, reject=0, done=0, fail=0, counters 0;
//    buffer contents not cleared (don't care). Reset mid-packet aborts it; next cycle idle.
//  - States: IDLE, LOAD, HEADER, PAYLOAD, PARITY (+ ERR_WAIT with macro).
//  - IDLE: start with addr!=3 and len!=0 -> latch addr/len, hdr={len,addr}, par<=hdr,
//    wr_idx<=0, go LOAD. Illegal start -> reject pulse next cycle, stay IDLE.
//  - LOAD: each wr_en writes buf[wr_idx], par<=par^wr_data, wr_idx++. Write of byte len-1
//    -> on that edge pkt_valid<=1, data_out<=hdr, go HEADER. start ignored outside IDLE.
//  - Transfer rule: presented byte is consumed at an edge where busy==0; next byte appears
//    on that same edge. busy==1 holds data_out and pkt_valid unchanged, any duration.
//  - HEADER consumed -> data_out<=buf[0], rd_idx<=1, go PAYLOAD.
//  - PAYLOAD: byte consumed -> next buf[rd_idx]; last (len-th) byte consumed ->
//    pkt_valid<=0, data_out<=par, go PARITY. pkt_valid never drops mid-payload.
//  - PARITY consumed -> data_out<=0, go IDLE, done=1 next cycle.
//  - Latency, busy=0: header at T, payload T+1..T+len, parity T+len+1, done T+len+2.
//  - Parity = XOR of header and all payload bytes, computed during LOAD.
//  - rd_idx/wr_idx are LEN_W bits; len=63 never wraps past index 62.
// CONFIGURATION
//  ROUTER_TX_RETRY_EN defined: PARITY consumed -> ERR_WAIT for 2 cycles sampling err.
//    err seen and retry_cnt<MAX_RETRY -> retry_cnt++, pkt_valid<=1, data_out<=hdr, HEADER
//    (buffer and par reused). Else -> IDLE, done pulse; fail pulses with it if err seen.
//    retry_cnt clears on each new start.
//  Not defined: no ERR_WAIT, no retry counter, err ignored, fail tied 0.
// TESTING
//  1 addr=1,len=3, load A1 B2 C3, busy=0 -> data_out 0D,A1,B2,C3 (pkt_valid=1), DD
//    (pkt_valid=0), done next cycle, tx_idle=1.
//  2 same packet, busy=1 for 3 cycles while B2 presented -> B2 held 4 cycles, no skip/dup.
//  3 start addr=3 len=5 -> reject pulse, tx_idle stays 1; then addr=0 len=0 -> reject.
//  4 addr=2,len=63, bytes 00..3E -> header FE, 63 payload bytes in order, parity correct.
//  5 reset in PAYLOAD after 2 bytes -> next cycle pkt_valid=0,data_out=0,tx_idle=1;
//    following packet sent correctly.
//  6 macro on, MAX_RETRY=2: err after parity -> header/payload resent identically; err
//    after 3 sends -> done+fail pulse; macro off: err ignored, fail=0.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input port: buffers a payload, then sends header, payload and parity.
// Optional parity-error resend is enabled by defining ROUTER_TX_RETRY_EN.
module router_pkt_tx #(
  parameter int WIDTH     = 8,
  parameter int LEN_W     = 6,
  parameter int MAX_RETRY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       dest_addr,
  input  logic [LEN_W-1:0] pay_len,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             busy,
  input  logic             err,
  output logic             pkt_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             tx_idle,
  output logic             reject,
  output logic             done,
  output logic             fail
);

  // Handshake: the byte on data_out (with pkt_valid) is consumed at a rising edge
  // where busy==0, and the next byte appears on that same edge; busy==1 holds both.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_ERR_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mem [0:2**LEN_W-1];
  logic [1:0]       addr_q;
  logic [LEN_W-1:0] len_q, wr_idx, rd_idx;
  logic [WIDTH-1:0] par, hdr, hdr_in;
  logic             legal, take, last_wr, last_rd;
  logic             pv_d, done_d, fail_d, reject_d;
  logic [WIDTH-1:0] dout_d;

  assign legal   = (dest_addr != 2'd3) && (pay_len != '0);
  assign take    = !busy;
  assign last_wr = wr_en && (wr_idx == len_q - LEN_W'(1));
  assign last_rd = (rd_idx == len_q);
  assign hdr     = {len_q[WIDTH-3:0], addr_q};
  assign hdr_in  = {pay_len[WIDTH-3:0], dest_addr};

`ifdef ROUTER_TX_RETRY_EN
  localparam int RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RCW-1:0] retry_cnt;
  logic           wait_cnt, err_seen, err_any, retry_go;

  assign err_any  = err_seen | err;
  assign retry_go = err_any && (retry_cnt < RCW'(MAX_RETRY));

  always_ff @(posedge clock) begin
    if (reset) begin
      retry_cnt <= '0;
      wait_cnt  <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      case (state)
        S_IDLE:   if (start && legal) retry_cnt <= '0;
        S_PARITY: if (take) begin
          wait_cnt <= 1'b0;
          err_seen <= 1'b0;
        end
        S_ERR_WAIT: begin
          wait_cnt <= 1'b1;
          err_seen <= err_any;
          if (wait_cnt && retry_go) retry_cnt <= retry_cnt + RCW'(1);
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = err | (MAX_RETRY != 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start && legal) state_nxt = S_LOAD;
      S_LOAD:    if (last_wr) state_nxt = S_HEADER;
      S_HEADER:  if (take) state_nxt = S_PAYLOAD;
      S_PAYLOAD: if (take && last_rd) state_nxt = S_PARITY;
`ifdef ROUTER_TX_RETRY_EN
      S_PARITY:   if (take) state_nxt = S_ERR_WAIT;
      S_ERR_WAIT: if (wait_cnt) state_nxt = retry_go ? S_HEADER : S_IDLE;
`else
      S_PARITY:   if (take) state_nxt = S_IDLE;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pv_d     = pkt_valid;
    dout_d   = data_out;
    done_d   = 1'b0;
    fail_d   = 1'b0;
    reject_d = 1'b0;
    case (state)
      S_IDLE:   reject_d = start && !legal;
      S_LOAD:   if (last_wr) begin
        pv_d   = 1'b1;
        dout_d = hdr;
      end
      S_HEADER: if (take) dout_d = mem[0];
      S_PAYLOAD: if (take) begin
        if (last_rd) begin
          pv_d   = 1'b0;
          dout_d = par;
        end else begin
          dout_d = mem[rd_idx];
        end
      end
      S_PARITY: if (take) begin
        dout_d = '0;
`ifndef ROUTER_TX_RETRY_EN
        done_d = 1'b1;
`endif
      end
`ifdef ROUTER_TX_RETRY_EN
      S_ERR_WAIT: if (wait_cnt) begin
        if (retry_go) begin
          pv_d   = 1'b1;
          dout_d = hdr;
        end else begin
          done_d = 1'b1;
          fail_d = err_any;
        end
      end
`endif
      default: ;
    endcase
  end

  assign tx_idle = (state == S_IDLE);

  // Buffer contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (!reset && state == S_LOAD && wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_valid <= 1'b0;
      data_out  <= '0;
      reject    <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      par       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
    end else begin
      pkt_valid <= pv_d;
      data_out  <= dout_d;
      reject    <= reject_d;
      done      <= done_d;
      fail      <= fail_d;
      case (state)
        S_IDLE: if (start && legal) begin
          addr_q <= dest_addr;
          len_q  <= pay_len;
          par    <= hdr_in;
          wr_idx <= '0;
        end
        S_LOAD: if (wr_en) begin
          par    <= par ^ wr_data;
          wr_idx <= wr_idx + LEN_W'(1);
        end
        S_HEADER:  if (take) rd_idx <= LEN_W'(1);
        S_PAYLOAD: if (take && !last_rd) rd_idx <= rd_idx + LEN_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed packets plus randomized traffic
// against a byte-stream model (header, payload, XOR parity) built in the bench.
module tb_router_pkt_tx;
  localparam int WIDTH     = 8;
  localparam int LEN_W     = 6;
  localparam int MAX_RETRY = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [1:0]       dest_addr = '0;
  logic [LEN_W-1:0] pay_len = '0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             busy = 1'b0;
  logic             err = 1'b0;
  logic             pkt_valid, tx_idle, reject, done, fail;
  logic [WIDTH-1:0] data_out;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] pay_q[$];
  logic [WIDTH-1:0] exp_q[$];

  router_pkt_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .MAX_RETRY(MAX_RETRY)) dut (
    .clock(clock), .reset(reset), .start(start), .dest_addr(dest_addr),
    .pay_len(pay_len), .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .err(err),
    .pkt_valid(pkt_valid), .data_out(data_out), .tx_idle(tx_idle),
    .reject(reject), .done(done), .fail(fail)
  );

  // clock / reset block
  always #5 clock = ~clock;

`ifndef ROUTER_TX_RETRY_EN
  // err must have no effect in the default build
  initial forever begin
    @(negedge clock);
    err = 1'($urandom_range(0, 1));
  end
`endif

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected stream: header {len,addr}, payload in order, XOR of all of them
  task automatic build_exp(input logic [1:0] addr, input logic [5:0] len);
    logic [7:0] p;
    exp_q.delete();
    p = {len, addr};
    exp_q.push_back(p);
    foreach (pay_q[k]) begin
      exp_q.push_back(pay_q[k]);
      p = p ^ pay_q[k];
    end
    exp_q.push_back(p);
  endtask

  task automatic fill_random(input int len);
    pay_q.delete();
    repeat (len) pay_q.push_back(8'($urandom));
  endtask

  task automatic start_and_load(input logic [1:0] addr, input logic [5:0] len, input bit rnd);
    build_exp(addr, len);
    @(negedge clock);
    start = 1'b1; dest_addr = addr; pay_len = len;
    @(negedge clock);
    start = 1'b0;
    chk("load_not_idle", 8'(tx_idle), 8'd0);
    for (int k = 0; k < int'(len); k++) begin
      if (rnd) begin
        repeat ($urandom_range(0, 2)) begin
          wr_en = 1'b0;
          start = 1'($urandom_range(0, 1));
          dest_addr = 2'($urandom); pay_len = 6'($urandom);
          @(negedge clock);
          chk("load_pv", 8'(pkt_valid), 8'd0);
        end
      end
      start = 1'b0; wr_en = 1'b1; wr_data = pay_q[k];
      @(negedge clock);
    end
    wr_en = 1'b0; start = 1'b0;
  endtask

  // Consume exp_q byte by byte; busy stretches are random or placed at hold_idx.
  task automatic stream_bytes(input int hold_idx, input int hold_n, input bit rnd);
    int n;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk("byte", data_out, exp_q[i]);
      chk("pkt_valid", 8'(pkt_valid), 8'(i < exp_q.size() - 1));
      if (i == hold_idx) n = hold_n;
      else if (rnd && $urandom_range(0, 3) == 0) n = $urandom_range(1, 3);
      else n = 0;
      repeat (n) begin
        busy = 1'b1;
        @(negedge clock);
        chk("hold_byte", data_out, exp_q[i]);
        chk("hold_pv", 8'(pkt_valid), 8'(i < exp_q.size() - 1));
      end
      busy = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len, input int hold_idx,
                          input int hold_n, input bit rnd, input int err_sends);
    int  sends;
    bit  again;
    bit  fail_exp;
    sends = 0;
    fail_exp = 1'b0;
    start_and_load(addr, len, rnd);
    do begin
      sends++;
      again = 1'b0;
      stream_bytes(hold_idx, hold_n, rnd);
`ifdef ROUTER_TX_RETRY_EN
      begin
        bit e;
        int slot;
        e = (sends <= err_sends);
        slot = $urandom_range(0, 1);
        chk("errwait_pv", 8'(pkt_valid), 8'd0);
        chk("errwait_busy", 8'(tx_idle), 8'd0);
        err = e && (slot == 0);
        @(negedge clock);
        err = e && (slot == 1);
        @(negedge clock);
        err = 1'b0;
        again = e && (sends <= MAX_RETRY);
        fail_exp = e;
      end
`endif
    end while (again);
    chk("done", 8'(done), 8'd1);
    chk("fail", 8'(fail), 8'(fail_exp));
    chk("idle_after", 8'(tx_idle), 8'd1);
    chk("dout_after", data_out, 8'd0);
    @(negedge clock);
    chk("done_pulse", 8'(done), 8'd0);
    chk("fail_pulse", 8'(fail), 8'd0);
  endtask

  task automatic try_reject(input logic [1:0] addr, input logic [5:0] len);
    @(negedge clock);
    start = 1'b1; dest_addr = addr; pay_len = len;
    @(negedge clock);
    start = 1'b0;
    chk("reject", 8'(reject), 8'd1);
    chk("reject_idle", 8'(tx_idle), 8'd1);
    @(negedge clock);
    chk("reject_pulse", 8'(reject), 8'd0);
    chk("reject_still_idle", 8'(tx_idle), 8'd1);
  endtask

  task automatic reset_mid_payload();
    fill_random(6);
    start_and_load(2'd0, 6'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("pre_reset_byte", data_out, exp_q[i]);
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("rst_pv", 8'(pkt_valid), 8'd0);
    chk("rst_dout", data_out, 8'd0);
    chk("rst_idle", 8'(tx_idle), 8'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_done", 8'(done), 8'd0);
    chk("post_rst_idle", 8'(tx_idle), 8'd1);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("reset_pv", 8'(pkt_valid), 8'd0);
    chk("reset_dout", data_out, 8'd0);
    chk("reset_idle", 8'(tx_idle), 8'd1);
    chk("reset_reject", 8'(reject), 8'd0);
    chk("reset_done", 8'(done), 8'd0);
    chk("reset_fail", 8'(fail), 8'd0);
    reset = 1'b0;

    pay_q = '{8'hA1, 8'hB2, 8'hC3};
    send_pkt(2'd1, 6'd3, -1, 0, 1'b0, 0);
    send_pkt(2'd1, 6'd3, 2, 3, 1'b0, 0);

    try_reject(2'd3, 6'd5);
    try_reject(2'd0, 6'd0);

    pay_q.delete();
    for (int k = 0; k < 63; k++) pay_q.push_back(8'(k));
    send_pkt(2'd2, 6'd63, -1, 0, 1'b0, 0);

    reset_mid_payload();
    fill_random(5);
    send_pkt(2'd1, 6'd5, -1, 0, 1'b0, 0);

`ifdef ROUTER_TX_RETRY_EN
    fill_random(4);
    send_pkt(2'd0, 6'd4, -1, 0, 1'b0, 1);
    fill_random(3);
    send_pkt(2'd2, 6'd3, -1, 0, 1'b0, 3);
`endif

    for (int p = 0; p < 25; p++) begin
      int len;
      len = ($urandom_range(0, 5) == 0) ? 63 : $urandom_range(1, 20);
      fill_random(len);
      send_pkt(2'($urandom_range(0, 2)), 6'(len), -1, 0, 1'b1, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) try_reject(2'd3, 6'($urandom_range(0, 63)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
